// File: rtl/laplace_stream_filter_pkg.sv
// Shared constants for the streaming Laplace filter: mode encodings and the
// guard bits added on top of the pixel width for the signed raw result.
package laplace_stream_filter_pkg;

    localparam logic [1:0] MODE_EXACT4  = 2'd0;
    localparam logic [1:0] MODE_APPROX4 = 2'd1;
    localparam logic [1:0] MODE_EXACT8  = 2'd2;

    // Raw result width is PW + RAW_GUARD: enough for 8*max - 0 and 0 - 8*max.
    localparam int RAW_GUARD = 4;

    function automatic int counter_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/laplace_stream_filter_kernel.sv
// Combinational 3x3 Laplace kernel: exact 4-/8-neighbour and approximate
// 4-neighbour (lower-part-OR adder) variants, with saturation to PW bits.
module laplace_stream_filter_kernel
    import laplace_stream_filter_pkg::*;
#(
    parameter int PW          = 8,
    parameter int APPROX_BITS = 3
) (
    input  logic [1:0]                     mode,
    input  logic [PW-1:0]                  a,
    input  logic [PW-1:0]                  b,
    input  logic [PW-1:0]                  c,
    input  logic [PW-1:0]                  d,
    input  logic [PW-1:0]                  e,
    input  logic [PW-1:0]                  f,
    input  logic [PW-1:0]                  g,
    input  logic [PW-1:0]                  h,
    input  logic [PW-1:0]                  i,
    output logic signed [PW+RAW_GUARD-1:0] raw,
    output logic [PW-1:0]                  pixel
);

    localparam int RW = PW + RAW_GUARD;

    function automatic logic [RW-1:0] ext(input logic [PW-1:0] p);
        return RW'(p);
    endfunction

    // Low part is a carry-free OR; the high part is an exact add.
    function automatic logic [RW-1:0] loa_add(input logic [RW-1:0] x, input logic [RW-1:0] y);
        logic [RW-1:0] s;
        s[APPROX_BITS-1:0]  = x[APPROX_BITS-1:0] | y[APPROX_BITS-1:0];
        s[RW-1:APPROX_BITS] = x[RW-1:APPROX_BITS] + y[RW-1:APPROX_BITS];
        return s;
    endfunction

    logic [RW-1:0] sum4;
    logic [RW-1:0] sum4_loa;
    logic [RW-1:0] sum8;
    logic [RW-1:0] res;

    always_comb begin
        sum4     = ext(b) + ext(d) + ext(f) + ext(h);
        sum4_loa = loa_add(loa_add(loa_add(ext(b), ext(d)), ext(f)), ext(h));
        sum8     = sum4 + ext(a) + ext(c) + ext(g) + ext(i);
        case (mode)
            MODE_APPROX4: res = (ext(e) << 2) - sum4_loa;
            MODE_EXACT8:  res = (ext(e) << 3) - sum8;
            default:      res = (ext(e) << 2) - sum4;
        endcase
        raw = $signed(res);
        if (res[RW-1]) begin
            pixel = '0;
        end else if (res[RW-2:PW] != '0) begin
            pixel = '1;
        end else begin
            pixel = res[PW-1:0];
        end
    end

endmodule

// File: rtl/laplace_stream_filter.sv
// Streaming 3x3 Laplace filter: two line buffers and a shift window build the
// neighbourhood around each accepted pixel; one registered output stage.
module laplace_stream_filter
    import laplace_stream_filter_pkg::*;
#(
    parameter int PW          = 8,
    parameter int ROWS        = 512,
    parameter int COLS        = 512,
    parameter int APPROX_BITS = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [1:0]                     mode,
    input  logic [PW-1:0]                  in_pixel,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [PW-1:0]                  out_pixel,
    output logic signed [PW+RAW_GUARD-1:0] out_raw,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_last
);

    localparam int CW  = counter_width(COLS);
    localparam int RCW = counter_width(ROWS);
    localparam logic [CW-1:0]  COL_MAX = CW'(COLS - 1);
    localparam logic [RCW-1:0] ROW_MAX = RCW'(ROWS - 1);

    logic [CW-1:0]  col;
    logic [RCW-1:0] row;

    // lb_top holds the row two above the incoming one, lb_mid the row just above.
    logic [PW-1:0] lb_top [COLS];
    logic [PW-1:0] lb_mid [COLS];
    logic [PW-1:0] top_rd;
    logic [PW-1:0] mid_rd;

    // Two older window columns: a/d/g oldest, b/e/h middle; newest column is live.
    logic [PW-1:0] w_a, w_b, w_d, w_e, w_g, w_h;

    logic                           accept;
    logic                           produce;
    logic                           last_pos;
    logic signed [PW+RAW_GUARD-1:0] k_raw;
    logic [PW-1:0]                  k_pixel;

    assign in_ready = out_ready | ~out_valid;
    assign accept   = in_valid & in_ready;
    assign produce  = accept && (row >= RCW'(2)) && (col >= CW'(2));
    assign last_pos = (row == ROW_MAX) && (col == COL_MAX);
    assign top_rd   = lb_top[col];
    assign mid_rd   = lb_mid[col];

    laplace_stream_filter_kernel #(
        .PW          (PW),
        .APPROX_BITS (APPROX_BITS)
    ) kernel (
        .mode  (mode),
        .a     (w_a),
        .b     (w_b),
        .c     (top_rd),
        .d     (w_d),
        .e     (w_e),
        .f     (mid_rd),
        .g     (w_g),
        .h     (w_h),
        .i     (in_pixel),
        .raw   (k_raw),
        .pixel (k_pixel)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            lb_top[col] <= mid_rd;
            lb_mid[col] <= in_pixel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            w_a       <= '0;
            w_b       <= '0;
            w_d       <= '0;
            w_e       <= '0;
            w_g       <= '0;
            w_h       <= '0;
            out_valid <= 1'b0;
            out_pixel <= '0;
            out_raw   <= '0;
            out_last  <= 1'b0;
        end else begin
            if (accept) begin
                if (col == COL_MAX) begin
                    col <= '0;
                    row <= (row == ROW_MAX) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                w_a <= w_b;
                w_b <= top_rd;
                w_d <= w_e;
                w_e <= mid_rd;
                w_g <= w_h;
                w_h <= in_pixel;
            end
            if (produce) begin
                out_valid <= 1'b1;
                out_pixel <= k_pixel;
                out_raw   <= k_raw;
                out_last  <= last_pos;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_laplace_stream_filter.sv
// Directed bench for laplace_stream_filter: three instances (4x4, 5x5, 6x6
// frames) share clock and reset; a negedge monitor captures transfers.
module tb_laplace_stream_filter;

    typedef struct {
        int pix;
        int raw;
        int last;
    } out_t;

    logic        clk;
    logic        rst;
    logic [1:0]  mode_a      [3];
    logic [7:0]  in_pixel_a  [3];
    logic        in_valid_a  [3];
    logic        in_ready_a  [3];
    logic [7:0]  out_pixel_a [3];
    logic [11:0] out_raw_a   [3];
    logic        out_valid_a [3];
    logic        out_ready_a [3];
    logic        out_last_a  [3];

    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;
    bit   bp       = 0;
    int   img [6][6];
    out_t cap_q [$];
    out_t exp_q [$];
    out_t ref_q [$];

    bit         stalled  [3];
    logic [7:0] held_pix [3];
    logic [11:0] held_raw [3];
    logic       held_last [3];

    for (genvar k = 0; k < 3; k++) begin : g_dut
        laplace_stream_filter #(
            .PW (8), .ROWS (4 + k), .COLS (4 + k), .APPROX_BITS (3)
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .mode      (mode_a[k]),
            .in_pixel  (in_pixel_a[k]),
            .in_valid  (in_valid_a[k]),
            .in_ready  (in_ready_a[k]),
            .out_pixel (out_pixel_a[k]),
            .out_raw   (out_raw_a[k]),
            .out_valid (out_valid_a[k]),
            .out_ready (out_ready_a[k]),
            .out_last  (out_last_a[k])
        );
    end

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // out_ready: constant 1, or toggled every cycle during backpressure runs
    initial begin
        for (int k = 0; k < 3; k++) out_ready_a[k] = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            for (int k = 0; k < 3; k++) out_ready_a[k] = bp ? ~out_ready_a[k] : 1'b1;
        end
    end

    // Monitor: capture transfers, check outputs hold while stalled
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (stalled[k]) begin
                check($sformatf("stall_valid_%0d", k), int'(out_valid_a[k]), 1);
                check($sformatf("stall_pix_%0d", k), int'(out_pixel_a[k]), int'(held_pix[k]));
                check($sformatf("stall_raw_%0d", k), int'(out_raw_a[k]), int'(held_raw[k]));
                check($sformatf("stall_last_%0d", k), int'(out_last_a[k]), int'(held_last[k]));
            end
            if (out_valid_a[k] && out_ready_a[k])
                cap_q.push_back('{int'(out_pixel_a[k]), int'($signed(out_raw_a[k])), int'(out_last_a[k])});
            stalled[k]   = out_valid_a[k] && !out_ready_a[k] && !rst;
            held_pix[k]  = out_pixel_a[k];
            held_raw[k]  = out_raw_a[k];
            held_last[k] = out_last_a[k];
        end
    end

    // Driver tasks
    task automatic push(input int k, input int pix, input int md, input bit rnd);
        bit acc;
        int guard;
        if (rnd) begin
            while ($urandom_range(0, 1) == 0) begin
                in_valid_a[k] = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        in_valid_a[k] = 1'b1;
        in_pixel_a[k] = 8'(pix);
        mode_a[k]     = 2'(md);
        guard = 0;
        acc   = 1'b0;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready_a[k];
            @(posedge clk);
            #1;
            guard++;
            if (guard > 200) begin
                check("push_timeout", 0, 1);
                acc = 1'b1;
            end
        end
    endtask

    task automatic send_frame(input int k, input int md, input bit rnd);
        int n = 4 + k;
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
                push(k, img[r][c], md, rnd);
        in_valid_a[k] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic clear_img();
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++)
                img[r][c] = 0;
    endtask

    task automatic ramp_img();
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++)
                img[r][c] = (r * 37 + c * 11 + r * c * 7) % 256;
    endtask

    function automatic int model_raw(input int r, input int c, input int md);
        int s4;
        int s8;
        s4 = img[r-1][c] + img[r][c-1] + img[r][c+1] + img[r+1][c];
        s8 = s4 + img[r-1][c-1] + img[r-1][c+1] + img[r+1][c-1] + img[r+1][c+1];
        return (md == 2) ? 8 * img[r][c] - s8 : 4 * img[r][c] - s4;
    endfunction

    function automatic int sat(input int raw);
        return (raw < 0) ? 0 : (raw > 255) ? 255 : raw;
    endfunction

    task automatic model_frame(input int n, input int md);
        int raw;
        for (int r = 1; r < n - 1; r++)
            for (int c = 1; c < n - 1; c++) begin
                raw = model_raw(r, c, md);
                exp_q.push_back('{sat(raw), raw, int'(r == n - 2 && c == n - 2)});
            end
    endtask

    // Scoreboard: compare captured outputs against exp_q, then empty both
    task automatic score(input string tag);
        int m;
        check({tag, "_count"}, cap_q.size(), exp_q.size());
        m = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
        for (int j = 0; j < m; j++) begin
            check($sformatf("%s_pix%0d", tag, j), cap_q[j].pix, exp_q[j].pix);
            check($sformatf("%s_raw%0d", tag, j), cap_q[j].raw, exp_q[j].raw);
            check($sformatf("%s_last%0d", tag, j), cap_q[j].last, exp_q[j].last);
        end
        cap_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int imp_raw [9] = '{0, -200, 0, -200, 800, -200, 0, -200, 0};
        int imp_pix [9] = '{0, 0, 0, 0, 255, 0, 0, 0, 0};
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid_a[k] = 1'b0;
            in_pixel_a[k] = '0;
            mode_a[k]     = 2'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset_valid_%0d", k), int'(out_valid_a[k]), 0);
            check($sformatf("reset_ready_%0d", k), int'(in_ready_a[k]), 1);
            check($sformatf("reset_pix_%0d", k), int'(out_pixel_a[k]), 0);
            check($sformatf("reset_raw_%0d", k), int'(out_raw_a[k]), 0);
            check($sformatf("reset_last_%0d", k), int'(out_last_a[k]), 0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Flat 4x4 frame of 100s
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++)
                img[r][c] = 100;
        cap_q.delete();
        send_frame(0, 0, 0);
        for (int j = 0; j < 4; j++) exp_q.push_back('{0, 0, int'(j == 3)});
        score("flat");

        // Impulse at (2,2) in a 5x5 frame
        clear_img();
        img[2][2] = 200;
        send_frame(1, 0, 0);
        for (int j = 0; j < 9; j++) exp_q.push_back('{imp_pix[j], imp_raw[j], int'(j == 8)});
        score("impulse");

        // Approximate vs exact 4-neighbour at centre (1,1)
        clear_img();
        img[1][1] = 10;
        img[0][1] = 3;
        img[1][0] = 3;
        img[1][2] = 3;
        img[2][1] = 3;
        send_frame(0, 1, 0);
        check("approx_count", cap_q.size(), 4);
        if (cap_q.size() > 0) begin
            check("approx_raw", cap_q[0].raw, 37);
            check("approx_pix", cap_q[0].pix, 37);
        end
        cap_q.delete();
        send_frame(0, 0, 0);
        check("exact4_count", cap_q.size(), 4);
        if (cap_q.size() > 0) check("exact4_raw", cap_q[0].raw, 28);
        cap_q.delete();
        send_frame(0, 3, 0);
        check("mode3_count", cap_q.size(), 4);
        if (cap_q.size() > 0) check("mode3_raw", cap_q[0].raw, 28);
        cap_q.delete();

        // 8-neighbour at centre (1,1)
        clear_img();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                img[r][c] = 10;
        img[1][1] = 20;
        send_frame(0, 2, 0);
        check("exact8_count", cap_q.size(), 4);
        if (cap_q.size() > 0) begin
            check("exact8_raw", cap_q[0].raw, 80);
            check("exact8_pix", cap_q[0].pix, 80);
        end
        cap_q.delete();

        // 6x6 ramp: clean run, then the same frame under backpressure
        ramp_img();
        send_frame(2, 0, 0);
        ref_q = cap_q;
        model_frame(6, 0);
        score("ramp_clean");
        bp = 1'b1;
        send_frame(2, 0, 1);
        bp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q = ref_q;
        score("ramp_stall");

        // Reset after pixel 10 of a 4x4 frame, then a clean frame
        ramp_img();
        for (int p = 0; p < 11; p++) push(0, 200 - p, 2, 0);
        in_valid_a[0] = 1'b0;
        rst = 1'b1;
        #2;
        check("midrst_valid", int'(out_valid_a[0]), 0);
        check("midrst_raw", int'(out_raw_a[0]), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cap_q.delete();
        send_frame(0, 0, 0);
        model_frame(4, 0);
        score("after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/laplace_stream_filter.md
Name: laplace_stream_filter

Overview:
- Streaming, parametrised successor to the combinational 5-point Laplace cell (inputs b,d,e,f,h).
- Accepts a raster-order pixel stream over a valid/ready handshake and buffers two image rows in internal line buffers.
- Forms the 3x3 neighbourhood and emits one filtered pixel per interior position, (ROWS-2)*(COLS-2) per frame, in raster order.
- Sits between the image source (file/DMA reader) and the output writer; replaces the per-pixel address arithmetic formerly done in the bench.

Parameters:
- PW, 8, pixel width in bits.
- ROWS, 512, image rows.
- COLS, 512, image columns (line-buffer depth).
- APPROX_BITS, 3, low bits computed by the approximate adder in mode 1; 0 < APPROX_BITS < PW.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- mode  in  2  0 = exact 4-neighbour, 1 = approximate 4-neighbour, 2 = exact 8-neighbour, 3 = reserved (treated as 0).
- in_pixel  in  PW  input pixel.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block can accept in_pixel.
- out_pixel  out  PW  saturated result.
- out_raw  out  PW+4  signed raw Laplacian.
- out_valid  out  1  output valid.
- out_ready  in  1  downstream accepts output.
- out_last  out  1  marks the final output pixel of the frame.

Behaviour:
- Reset values: out_valid = 0, out_pixel = 0, out_raw = 0, out_last = 0, in_ready = 1. Row and column counters are 0 and the window is cleared. Line-buffer contents are don't-care.
- Input transfer occurs when in_valid and in_ready are both high. Output transfer occurs when out_valid and out_ready are both high.
- in_ready = out_ready OR NOT out_valid (single output stage, no bubble).
- Input counters:
  - col increments per accepted pixel.
  - At col = COLS-1, col wraps to 0 and row increments.
  - At row = ROWS-1 and col = COLS-1, both wrap to 0 (next frame).
- Window neighbourhood for centre (r,c): a = (r-1,c-1), b = (r-1,c), c' = (r-1,c+1), d = (r,c-1), e = (r,c), f = (r,c+1), g = (r+1,c-1), h = (r+1,c), i = (r+1,c+1).
- Output generation:
  - An output is produced when the accepted pixel has row >= 2 and col >= 2; that pixel is the "i" position of the window.
  - Latency: out_valid rises in the cycle after the accepting edge.
  - No output is produced for the first two rows or the first two columns of each row.
- Arithmetic, signed, width PW+4:
  - mode 0: raw = 4e - (b+d+f+h).
  - mode 2: raw = 8e - (sum of all eight neighbours).
  - mode 1: as mode 0, but each addition within b+d+f+h uses a lower-part-OR adder. The low APPROX_BITS bits are the bitwise OR of the operands, with no carry out of the low part. The high part is an exact add.
- Saturation: out_pixel = 0 if raw < 0; 2^PW-1 if raw > 2^PW-1; else raw[PW-1:0].
- out_last = 1 with the output for centre (ROWS-2, COLS-2).
- Mode changes:
  - mode is sampled with each accepted input pixel.
  - Changing mode mid-frame affects only outputs whose "i" pixel is accepted after the change.
- Stall: while out_valid and NOT out_ready, all outputs, the window and the counters hold stable.
- in_valid low: counters and window hold; pending output remains until transferred.
- Reset mid-frame: clears counters and outputs immediately. The next accepted pixel is treated as (0,0).

Decomposition:
- Shared header laplace_defs.vh holds:
  - MODE_EXACT4 = 0, MODE_APPROX4 = 1, MODE_EXACT8 = 2.
  - The raw-width macro PW+4.
- Sub-module laplace_kernel: purely combinational. Inputs are the nine window pixels and mode; outputs are raw and the saturated pixel. It contains the lower-part-OR adder and is reusable by the existing bench flow.
- Top level holds:
  - the two COLS-deep line buffers (inferred RAM, one write and one read per accepted pixel);
  - the 3x3 shift window;
  - the counters;
  - the output register and handshake.

Test Plan:
- Flat frame (ROWS = COLS = 4, all pixels 100, mode 0, out_ready = 1) -> exactly 4 outputs, all out_pixel = 0 and out_raw = 0; out_last only on the 4th.
- Impulse (ROWS = COLS = 5, centre (2,2) = 200, others 0, mode 0) -> for centre (2,2) raw = 800 and pixel = 255. For centres (1,2), (2,1), (2,3) and (3,2), raw = -200 and pixel = 0. The other four outputs are 0.
- Approximate mode (neighbours b = d = f = h = 3, e = 10, APPROX_BITS = 3, mode 1):
  - OR-sum = 3; raw = 40 - 3 = 37.
  - Compare with mode 0: raw = 28. Both must match.
- 8-neighbour (all neighbours 10, e = 20, mode 2) -> raw = 160 - 80 = 80, pixel = 80.
- Backpressure: toggle out_ready 1/0 each cycle and drive in_valid randomly on a 6x6 ramp image. Required response:
  - the output sequence is identical to the no-stall run (16 pixels);
  - no output is lost or duplicated;
  - outputs stay stable while stalled.
- Reset at mid-frame pixel 10, then send a full 4x4 frame -> exactly 4 outputs, matching the clean-run values.
